// File: rtl/dmem_pkg_51.sv
// Shared types and helpers for the parametrised data-memory bank.
package dmem_pkg_51;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned BYTES      = DATA_W_DEF / 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Control half of a read-pipeline stage; the data word travels alongside.
  typedef struct packed {
    logic valid;
    logic err;
  } rd_ctl_t;

  // Ceiling log2, with clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned bytes_of(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/dmem_rd_pipe_51.sv
// Read-response delay line: 1 or 2 register stages carrying {valid, err, data}.
module dmem_rd_pipe_51
  import dmem_pkg_51::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_err,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_err,
  output logic [DATA_W-1:0] out_data
);

  localparam int unsigned STAGES = (RD_LAT >= 2) ? 2 : 1;

  rd_ctl_t           ctl_chain  [STAGES+1];
  logic [DATA_W-1:0] data_chain [STAGES+1];

  assign ctl_chain[0]  = '{valid: in_valid, err: in_err};
  assign data_chain[0] = in_data;

  // Data registers only load on a valid beat so the output holds between responses.
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    rd_ctl_t           ctl_q, ctl_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
      ctl_d.valid = ctl_chain[g].valid;
      ctl_d.err   = ctl_chain[g].valid & ctl_chain[g].err;
      data_d      = ctl_chain[g].valid ? data_chain[g] : data_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        ctl_q  <= '0;
        data_q <= '0;
      end else begin
        ctl_q  <= ctl_d;
        data_q <= data_d;
      end
    end

    assign ctl_chain[g+1]  = ctl_q;
    assign data_chain[g+1] = data_q;
  end

  assign out_valid = ctl_chain[STAGES].valid;
  assign out_err   = ctl_chain[STAGES].err;
  assign out_data  = data_chain[STAGES];

endmodule

// File: rtl/dmem_bank_51.sv
// Data-memory bank: byte-enable writes, pipelined reads with write-first bypass,
// address error reporting and a word-per-cycle hardware clear engine.
module dmem_bank_51
  import dmem_pkg_51::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned BYTE_ADDR = 1
) (
  input  logic                clk_51,
  input  logic                rst_51,
  output logic                rdy_51,
  input  logic                rreq_51,
  input  logic [ADDR_W-1:0]   raddr_51,
  output logic                rvalid_51,
  output logic [DATA_W-1:0]   rdata_51,
  output logic                rerr_51,
  input  logic                wreq_51,
  input  logic [ADDR_W-1:0]   waddr_51,
  input  logic [DATA_W-1:0]   wdata_51,
  input  logic [DATA_W/8-1:0] wbe_51,
  output logic                werr_51,
  input  logic                clr_51
);

  localparam int unsigned NB     = bytes_of(DATA_W);
  localparam int unsigned OFF_W  = clog2(NB);
  localparam int unsigned OFF_WM = (OFF_W == 0) ? 1 : OFF_W;
  localparam int unsigned IDX_W  = (clog2(DEPTH) == 0) ? 1 : clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              rdy_q, rdy_d;
  logic              werr_q, werr_d;
  logic              clr_we_c;

  logic              rd_acc_c, wr_acc_c, clr_acc_c, wr_ok_c;
  logic [ADDR_W-1:0] ridx_full_c, widx_full_c;
  logic [IDX_W-1:0]  ridx_c, widx_c;
  logic              rerr_dec_c, werr_dec_c;
  logic [DATA_W-1:0] rd_word_c;

  logic [NB-1:0]     mem_we_c;
  logic [IDX_W-1:0]  mem_widx_c;
  logic [DATA_W-1:0] mem_wdata_c;

  assign rd_acc_c  = rreq_51 & rdy_q;
  assign wr_acc_c  = wreq_51 & rdy_q;
  assign clr_acc_c = clr_51 & rdy_q;

  // Address decode: word index plus range / alignment error.
  always_comb begin
    ridx_full_c = (BYTE_ADDR != 0) ? (raddr_51 >> OFF_W) : raddr_51;
    widx_full_c = (BYTE_ADDR != 0) ? (waddr_51 >> OFF_W) : waddr_51;
    ridx_c      = ridx_full_c[IDX_W-1:0];
    widx_c      = widx_full_c[IDX_W-1:0];
    rerr_dec_c  = (ridx_full_c >= ADDR_W'(DEPTH)) ||
                  ((BYTE_ADDR != 0) && (OFF_W != 0) && (raddr_51[OFF_WM-1:0] != '0));
    werr_dec_c  = (widx_full_c >= ADDR_W'(DEPTH)) ||
                  ((BYTE_ADDR != 0) && (OFF_W != 0) && (waddr_51[OFF_WM-1:0] != '0));
    wr_ok_c     = wr_acc_c & ~werr_dec_c;
  end

  // FSM state register.
  always_ff @(posedge clk_51) begin
    if (rst_51) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (clr_acc_c) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == IDX_W'(DEPTH - 1)) begin
          state_d = IDLE;
          ptr_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    clr_we_c = 1'b0;
    rdy_d    = 1'b1;
    clr_we_c = (state_q == CLEAR);
    rdy_d    = (state_d == IDLE);
  end

  // Single array write port; reset blocks every write so an abandoned clear stops cleanly.
  always_comb begin
    mem_we_c    = '0;
    mem_widx_c  = widx_c;
    mem_wdata_c = wdata_51;
    if (!rst_51) begin
      if (clr_we_c) begin
        mem_we_c    = '1;
        mem_widx_c  = ptr_q;
        mem_wdata_c = '0;
      end else if (wr_ok_c) begin
        mem_we_c    = wbe_51;
      end
    end
  end

  always_ff @(posedge clk_51) begin
    for (int unsigned b = 0; b < NB; b++) begin
      if (mem_we_c[b]) mem_q[mem_widx_c][8*b +: 8] <= mem_wdata_c[8*b +: 8];
    end
  end

  // Read data with write-first bypass of a same-cycle write to the same word.
  always_comb begin
    rd_word_c = mem_q[ridx_c];
    if (wr_ok_c && (widx_c == ridx_c)) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (wbe_51[b]) rd_word_c[8*b +: 8] = wdata_51[8*b +: 8];
      end
    end
    if (rerr_dec_c) rd_word_c = '0;
  end

  always_comb begin
    werr_d = wr_acc_c & werr_dec_c;
  end

  always_ff @(posedge clk_51) begin
    if (rst_51) begin
      rdy_q  <= 1'b1;
      werr_q <= 1'b0;
    end else begin
      rdy_q  <= rdy_d;
      werr_q <= werr_d;
    end
  end

  dmem_rd_pipe_51 #(
    .RD_LAT (RD_LAT),
    .DATA_W (DATA_W)
  ) u_rd_pipe (
    .clk       (clk_51),
    .rst       (rst_51),
    .in_valid  (rd_acc_c),
    .in_err    (rerr_dec_c),
    .in_data   (rd_word_c),
    .out_valid (rvalid_51),
    .out_err   (rerr_51),
    .out_data  (rdata_51)
  );

  assign rdy_51  = rdy_q;
  assign werr_51 = werr_q;

endmodule

// File: doc/dmem_bank_51.md
Name: dmem_bank_51

Overview:
Parametrised data-memory bank for the single-cycle/pipelined processor. It succeeds the fixed 32-bit combinational-read data memory with these features:
- configurable width, depth and read latency
- byte-enable writes
- byte- or word-addressing
- address error reporting
- a hardware clear engine
Sits between the processor data port and the backing array; the processor samples rdata_51 only on rvalid_51.

Parameters:
DATA_W, 32, data word width in bits (multiple of 8)
DEPTH, 512, number of words
ADDR_W, 32, address port width
RD_LAT, 1, read latency in cycles, legal values 1 or 2
BYTE_ADDR, 1, 1 = byte addresses (word index = addr >> log2(DATA_W/8)), 0 = addresses are word indices

Ports:
clk_51  in  1  clock, all logic on rising edge
rst_51  in  1  synchronous active-high reset
rdy_51  out  1  bank accepts requests this cycle
rreq_51  in  1  read request, accepted when rdy_51=1
raddr_51  in  ADDR_W  read address
rvalid_51  out  1  read response valid, single-cycle pulse
rdata_51  out  DATA_W  read data, 0 on error
rerr_51  out  1  read error, qualified by rvalid_51
wreq_51  in  1  write request, accepted when rdy_51=1
waddr_51  in  ADDR_W  write address
wdata_51  in  DATA_W  write data
wbe_51  in  DATA_W/8  byte enables, bit i controls bits [8i+7:8i]
werr_51  out  1  write error pulse, one cycle after the rejected write
clr_51  in  1  start hardware clear, accepted when rdy_51=1

Behaviour:
- Reset (synchronous, active-high) returns control to defaults:
  - outputs: rdy_51=1, rvalid_51=0, rdata_51=0, rerr_51=0, werr_51=0
  - read pipeline flushed; FSM to IDLE
  - array contents are NOT altered by reset.
- FSM states:
  - IDLE: rdy_51=1. Accepted clr_51 -> CLEAR next cycle, clear pointer = 0.
  - CLEAR: rdy_51=0. Writes 0 to word[ptr] each cycle, ptr++. When ptr = DEPTH-1 is written -> IDLE. Clear takes exactly DEPTH cycles.
- Requests while rdy_51=0 are ignored: no write, no rvalid, no werr. The requester holds until rdy_51=1.
- Address decode: word index idx = BYTE_ADDR ? addr >> log2(DATA_W/8) : addr. The access is an error if:
  - idx >= DEPTH, or
  - BYTE_ADDR=1 and the low byte-offset bits are not 0.
- Write:
  - Accepted non-error wreq at edge N updates word[idx] at edge N, only the bytes with wbe_51 set.
  - wbe_51 = 0 is a legal no-op.
  - Error write: array untouched; werr_51=1 during cycle N+1.
- Read:
  - Accepted rreq at edge N gives rvalid_51=1 in the cycle following edge N+RD_LAT-1, i.e. RD_LAT cycles after acceptance.
  - rdata_51 is the word at acceptance time; error gives rdata_51=0 and rerr_51=1.
  - rvalid_51 and rerr_51 are 0 in all other cycles. rdata_51 holds its last value when rvalid_51=0.
  - Back-to-back reads: one per cycle, fully pipelined.
- Same-cycle read and write to the same word: the read returns write-first merged data, i.e. old bytes plus the enabled new bytes.
- clr_51 with wreq_51 in the same cycle: the write is performed, then the clear overwrites it.
- rreq_51 in the clr_51 cycle: served normally. Reads already in the pipeline complete during CLEAR.
- Reset mid-CLEAR: clear is abandoned. Already-cleared words stay 0; the remainder are untouched.
- No # delays in RTL. Array is inferred memory, initialisable via $readmemh by the bench.

Decomposition:
- Package dmem_pkg_51: FSM state enum {IDLE, CLEAR}; function clog2; constant BYTES = DATA_W/8.
- Sub-module dmem_rd_pipe_51 (parametrised by RD_LAT and DATA_W): delays {valid, err, data} through 1 or 2 register stages and clears them on reset.
- The top level holds the array, decode, byte-merge, bypass and FSM.

Test Plan:
- RD_LAT=1, BYTE_ADDR=1: write 0x0000000E to addr 80 (wbe=4'hF), then read addr 80 -> rvalid_51 1 cycle later, rdata_51=0x0000000E, rerr_51=0.
- Byte enables: word at addr 64 = 0x11223344; write 0xAABBCCDD with wbe=4'b0101 -> read returns 0x11BB33DD. Same-cycle read to addr 64 also returns 0x11BB33DD.
- Errors: read addr 66 (misaligned) -> rvalid_51=1, rerr_51=1, rdata_51=0. Write addr 4*DEPTH -> werr_51 pulse next cycle, and a full-array checksum is unchanged.
- RD_LAT=2: reads of addrs 0, 4, 8 on consecutive cycles (preloaded 1, 2, 3) -> rvalid_51 high for 3 consecutive cycles starting 2 cycles after the first, data 1, 2, 3 in order.
- Clear with DEPTH=16:
  - pulse clr_51 -> rdy_51 low for exactly 16 cycles.
  - a wreq held during CLEAR is performed only after rdy_51 returns.
  - all 16 words read back 0, except the held write.
- Reset mid-clear: assert rst_51 at clear cycle 5 -> next cycle rdy_51=1, rvalid_51=0. Words 0..4 read 0; words 5..15 keep their preloaded values.
